alu_dp_sequencer: RTL

Sequences ARM-style data-processing instructions through the shared combinational ALU. Accepts one decoded instruction per handshake, evaluates its condition code against the architectural NZCV register, drives the ALU, and writes back the result. Owns the NZCV register, updating it per the S bit and the opcode class. Sits between the decode stage and the register-file write port.

---
 rtl/alu_seq_pkg.sv | 57 +++++
 rtl/alu_cond_eval.sv | 42 ++++
 rtl/alu_dp_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the data-processing sequencer.
// State encoding, ARM condition codes, opcode classes and NZCV bit positions.
package alu_seq_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // ARM condition field encodings
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Opcode encodings shared with the ALU function select
    localparam logic [3:0] OPC_AND = 4'h0;
    localparam logic [3:0] OPC_EOR = 4'h1;
    localparam logic [3:0] OPC_SUB = 4'h2;
    localparam logic [3:0] OPC_RSC = 4'h7;
    localparam logic [3:0] OPC_TST = 4'h8;
    localparam logic [3:0] OPC_CMP = 4'hA;
    localparam logic [3:0] OPC_CMN = 4'hB;
    localparam logic [3:0] OPC_MOV = 4'hD;

    // NZCV bit positions within the flags register
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    // TST/TEQ/CMP/CMN: flags only, never a register write
    function automatic logic is_test(input logic [3:0] opc);
        return (opc[3:2] == 2'b10);
    endfunction

    // Arithmetic class takes C and V from the adder; everything else is logical
    function automatic logic is_arith(input logic [3:0] opc);
        return ((opc >= OPC_SUB) && (opc <= OPC_RSC)) || (opc == OPC_CMP) || (opc == OPC_CMN);
    endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// alu_cond_eval: combinational ARM condition-code check against NZCV.
// Used by alu_dp_sequencer only when ALU_SEQ_COND_EN is defined.
module alu_cond_eval
    import alu_seq_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[NZCV_N];
    assign z = nzcv[NZCV_Z];
    assign c = nzcv[NZCV_C];
    assign v = nzcv[NZCV_V];

    // Decode the condition field into a single pass/fail bit
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_dp_sequencer.sv
// alu_dp_sequencer: three-cycle IDLE/EXEC/WB sequencer for data-processing
// instructions through an external combinational ALU. Owns NZCV.
// Optional build macro: ALU_SEQ_COND_EN enables condition-code evaluation;
// without it every instruction executes and SKIPPED stays low.
module alu_dp_sequencer
    import alu_seq_pkg::*;
#(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [3:0]        REQ_COND,
    input  logic [3:0]        REQ_OPC,
    input  logic              REQ_S,
    input  logic [3:0]        REQ_RD,
    input  logic [DATA_W-1:0] REQ_A,
    input  logic [DATA_W-1:0] REQ_B,
    input  logic              REQ_SHC,
    output logic [3:0]        ALU_FN,
    output logic [DATA_W-1:0] ALU_LEFT,
    output logic [DATA_W-1:0] ALU_RIGHT,
    output logic              ALU_CIN,
    input  logic [DATA_W-1:0] ALU_RESULT,
    input  logic              ALU_Z,
    input  logic              ALU_N,
    input  logic              ALU_C,
    input  logic              ALU_V,
    output logic              WB_EN,
    output logic [3:0]        WB_RD,
    output logic [DATA_W-1:0] WB_DATA,
    output logic [3:0]        FLAGS,
    input  logic              FLAG_WE,
    input  logic [3:0]        FLAG_IN,
    output logic              DONE,
    output logic              SKIPPED
);

    state_t              state;

    logic [3:0]          opc_p0;
    logic                s_p0;
    logic [3:0]          rd_p0;
    logic [DATA_W-1:0]   a_p0;
    logic [DATA_W-1:0]   b_p0;
    logic                shc_p0;

    logic                pass_p1;
    logic [3:0]          nzcv_p1;

    logic                done_q;
    logic                wb_en_q;
    logic [3:0]          wb_rd_q;
    logic [DATA_W-1:0]   wb_data_q;
    logic [3:0]          flags_q;

    logic                cond_pass;
    logic                flag_upd;
    logic [3:0]          flag_next;

`ifdef ALU_SEQ_COND_EN
    logic [3:0]          cond_p0;
    logic                skipped_q;

    alu_cond_eval u_cond_eval (
        .cond (cond_p0),
        .nzcv (flags_q),
        .pass (cond_pass)
    );

    // Skip pulse accompanies DONE when the condition failed in EXEC
    always_ff @(posedge CLK) begin
        if (RESET) begin
            skipped_q <= 1'b0;
        end else begin
            skipped_q <= (state == EXEC) && !cond_pass;
        end
    end

    assign SKIPPED = skipped_q;
`else
    logic                unused_cond;

    assign unused_cond = ^REQ_COND;
    assign cond_pass   = 1'b1;
    assign SKIPPED     = 1'b0;
`endif

    assign REQ_READY = (state == IDLE);
    assign ALU_FN    = opc_p0;
    assign ALU_LEFT  = a_p0;
    assign ALU_RIGHT = b_p0;
    assign ALU_CIN   = flags_q[NZCV_C];
    assign WB_EN     = wb_en_q;
    assign WB_RD     = wb_rd_q;
    assign WB_DATA   = wb_data_q;
    assign DONE      = done_q;
    assign FLAGS     = flags_q;

    // Accept in IDLE, capture ALU result in EXEC, retire in WB
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            opc_p0    <= OPC_MOV;
            a_p0      <= '0;
            b_p0      <= '0;
        end else begin
            done_q  <= 1'b0;
            wb_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        state  <= EXEC;
                        opc_p0 <= REQ_OPC;
                        s_p0   <= REQ_S;
                        rd_p0  <= REQ_RD;
                        a_p0   <= REQ_A;
                        b_p0   <= REQ_B;
                        shc_p0 <= REQ_SHC;
`ifdef ALU_SEQ_COND_EN
                        cond_p0 <= REQ_COND;
`endif
                    end
                end
                EXEC: begin
                    state     <= WB;
                    pass_p1   <= cond_pass;
                    nzcv_p1   <= {ALU_N, ALU_Z, ALU_C, ALU_V};
                    wb_data_q <= ALU_RESULT;
                    wb_rd_q   <= rd_p0;
                    wb_en_q   <= cond_pass && !is_test(opc_p0);
                    done_q    <= 1'b1;
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sequencer flag update happens on the WB edge of a passing S/test instruction
    always_comb begin
        flag_upd  = (state == WB) && pass_p1 && (s_p0 || is_test(opc_p0));
        flag_next = nzcv_p1;
        if (!is_arith(opc_p0)) begin
            flag_next = {nzcv_p1[NZCV_N], nzcv_p1[NZCV_Z], shc_p0, flags_q[NZCV_V]};
        end
    end

    // NZCV register: sequencer update beats an external MSR write on the same edge
    always_ff @(posedge CLK) begin
        if (RESET) begin
            flags_q <= FLAGS_RESET;
        end else if (flag_upd) begin
            flags_q <= flag_next;
        end else if (FLAG_WE) begin
            flags_q <= FLAG_IN;
        end
    end

endmodule
